// File: rtl/tick_bcd_display.sv
// tick_bcd_display: synchronizes the divider's slow level, counts its rising
// edges on a 4-digit BCD up/down counter, and scans the digits onto a
// common-anode 7-segment display (active-low anodes and segments).
module tick_bcd_display #(
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cnt_in,
    input  logic        en,
    input  logic        up,
    input  logic        ld,
    input  logic [15:0] ld_val,
    output logic [15:0] bcd,
    output logic        tc,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    // Synchronizer chain and edge detector
    logic s1, s2, s3;
    logic tick;

    // Counter next-state
    logic [15:0] ld_clamped;
    logic [15:0] inc_val;
    logic [15:0] dec_val;
    logic        inc_wrap;
    logic        dec_wrap;
    logic [15:0] bcd_next;
    logic        tc_next;

    // Display scan
    logic [SCAN_BITS-1:0] scan;
    logic [1:0]           dsel;
    logic [3:0]           digit;
    logic [3:0]           an_next;
    logic [6:0]           seg_next;

    // Active-low gfedcba glyphs; anything outside 0-9 is blanked.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Three-flop synchronizer; preset high so a level already high at reset
    // release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the chain shift one stage
            // per clock; blocking ones would collapse it into a single flop.
            s1 <= cnt_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // Digit-wise increment/decrement with ripple carry/borrow, plus load clamp.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        inc_val    = bcd;
        dec_val    = bcd;
        ld_clamped = ld_val;
        inc_wrap   = 1'b1;
        dec_wrap   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ld_val[4*i +: 4] > 4'd9) begin
                ld_clamped[4*i +: 4] = 4'd9;
            end
            if (inc_wrap) begin
                if (bcd[4*i +: 4] >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    inc_wrap          = 1'b0;
                end
            end
            if (dec_wrap) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    dec_wrap          = 1'b0;
                end
            end
        end
    end

    // Per-edge priority: load, then enabled tick, then hold.
    always_comb begin
        bcd_next = bcd;
        tc_next  = 1'b0;
        if (ld) begin
            bcd_next = ld_clamped;
        end else if (tick && en) begin
            if (up) begin
                bcd_next = inc_val;
                tc_next  = inc_wrap;
            end else begin
                bcd_next = dec_val;
                tc_next  = dec_wrap;
            end
        end
    end

    // Count register and registered wrap pulse.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            bcd <= 16'h0000;
            tc  <= 1'b0;
        end else begin
            bcd <= bcd_next;
            tc  <= tc_next;
        end
    end

    // Free-running scan counter; the top two bits pick the lit digit.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            scan <= '0;
        end else begin
            scan <= scan + SCAN_BITS'(1);
        end
    end

    assign dsel = scan[SCAN_BITS-1 -: 2];

    // Anode and segment pattern for the currently selected digit.
    always_comb begin
        digit    = bcd[{dsel, 2'b00} +: 4];
        an_next  = ~(4'b0001 << dsel);
        seg_next = decode(digit);
    end

    // an and seg share one register stage so they always switch together.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_tick_bcd_display.sv
// tb_tick_bcd_display: scoreboard bench for tick_bcd_display. A behavioural
// model (decimal arithmetic) pushes the expected outputs every clock; a
// checker pops and compares them on the falling edge. Directed checks cover
// tick latency, wrap pulses, load clamping, priority and the display scan.
module tb_tick_bcd_display;

    localparam int SB = 4;

    logic        clk;
    logic        RESET;
    logic        cnt_in;
    logic        en;
    logic        up;
    logic        ld;
    logic [15:0] ld_val;
    logic [15:0] bcd;
    logic        tc;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_errors = 0;

    tick_bcd_display #(.SCAN_BITS(SB)) dut (
        .clk    (clk),
        .RESET  (RESET),
        .cnt_in (cnt_in),
        .en     (en),
        .up     (up),
        .ld     (ld),
        .ld_val (ld_val),
        .bcd    (bcd),
        .tc     (tc),
        .an     (an),
        .seg    (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] bcd;
        logic        tc;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_ld(input logic [15:0] x);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            int n;
            n = int'(x[4*i +: 4]);
            if (n > 9) n = 9;
            r = r * 10 + n;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    int         m_val;
    logic       m_s1, m_s2, m_s3;
    logic       m_tc;
    int         m_scan;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    always @(posedge clk or posedge RESET) begin
        if (RESET) begin
            m_val  = 0;
            m_s1   = 1'b1;
            m_s2   = 1'b1;
            m_s3   = 1'b1;
            m_tc   = 1'b0;
            m_scan = 0;
            m_an   = 4'b1110;
            m_seg  = 7'b1000000;
            sb_q.delete();
        end else begin
            logic        m_tick;
            int          d;
            logic [15:0] cur;
            exp_t        e;
            m_tick = m_s2 & ~m_s3;
            d      = m_scan >> (SB - 2);
            cur    = to_bcd(m_val);
            m_an   = ~(4'b0001 << d);
            m_seg  = glyph(int'(cur[4*d +: 4]));
            if (ld) begin
                m_val = from_ld(ld_val);
                m_tc  = 1'b0;
            end else if (m_tick && en) begin
                if (up) begin
                    m_tc  = (m_val == 9999);
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_tc  = (m_val == 0);
                    m_val = (m_val + 9999) % 10000;
                end
            end else begin
                m_tc = 1'b0;
            end
            m_s3   = m_s2;
            m_s2   = m_s1;
            m_s1   = cnt_in;
            m_scan = (m_scan + 1) % (1 << SB);
            e.bcd  = to_bcd(m_val);
            e.tc   = m_tc;
            e.an   = m_an;
            e.seg  = m_seg;
            sb_q.push_back(e);
        end
    end

    // Scoreboard checker: compare each pushed expectation half a cycle later.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_bcd", bcd, e.bcd);
            check("sb_tc", tc, e.tc);
            check("sb_an", an, e.an);
            check("sb_seg", seg, e.seg);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [15:0] exp, input string tag);
        ld     = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
        check(tag, bcd, exp);
        check({tag, "_tc"}, tc, 1'b0);
    endtask

    // One cnt_in high/low period; checks update latency, tc width and that
    // the falling edge changes nothing.
    task automatic tick_pulse(input logic [15:0] prev, input logic [15:0] exp,
                              input logic exp_tc, input string tag);
        cnt_in = 1'b1;
        wait_cycles(2);
        check({tag, "_hold"}, bcd, prev);
        @(negedge clk);
        check({tag, "_bcd"}, bcd, exp);
        check({tag, "_tc"}, tc, exp_tc);
        @(negedge clk);
        check({tag, "_tc_end"}, tc, 1'b0);
        cnt_in = 1'b0;
        wait_cycles(4);
        check({tag, "_fall"}, bcd, exp);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int an_hits [4];
        RESET  = 1'b0;
        cnt_in = 1'b1;
        en     = 1'b1;
        up     = 1'b1;
        ld     = 1'b0;
        ld_val = 16'h0000;
        #1 RESET = 1'b1;
        wait_cycles(2);
        check("rst_bcd", bcd, 16'h0000);
        check("rst_tc", tc, 1'b0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);

        // Release with cnt_in held high: no tick.
        RESET = 1'b0;
        wait_cycles(20);
        check("rel_high_bcd", bcd, 16'h0000);
        check("rel_high_tc", tc, 1'b0);

        // Count up on two rising edges.
        cnt_in = 1'b0;
        wait_cycles(4);
        tick_pulse(16'h0000, 16'h0001, 1'b0, "up1");
        tick_pulse(16'h0001, 16'h0002, 1'b0, "up2");

        // Wrap upward.
        do_load(16'h9998, 16'h9998, "ld9998");
        tick_pulse(16'h9998, 16'h9999, 1'b0, "up9999");
        tick_pulse(16'h9999, 16'h0000, 1'b1, "wrap_up");

        // Wrap downward, then clamped load.
        up = 1'b0;
        do_load(16'h0000, 16'h0000, "ld0000");
        tick_pulse(16'h0000, 16'h9999, 1'b1, "wrap_dn");
        tick_pulse(16'h9999, 16'h9998, 1'b0, "dn9998");
        do_load(16'hA3F1, 16'h9391, "ld_clamp");

        // Load coincident with a tick: load wins, tick is discarded.
        up     = 1'b1;
        cnt_in = 1'b1;
        wait_cycles(2);
        ld     = 1'b1;
        ld_val = 16'h0042;
        @(negedge clk);
        ld = 1'b0;
        check("ld_tick_bcd", bcd, 16'h0042);
        check("ld_tick_tc", tc, 1'b0);
        @(negedge clk);
        check("ld_tick_after", bcd, 16'h0042);
        cnt_in = 1'b0;
        wait_cycles(4);

        // Tick with en low: hold.
        en = 1'b0;
        tick_pulse(16'h0042, 16'h0042, 1'b0, "en_off");
        en = 1'b1;

        // Display scan with 1234.
        do_load(16'h1234, 16'h1234, "ld1234");
        wait_cycles(2);
        for (int i = 0; i < 4; i++) an_hits[i] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin an_hits[0]++; check("scan_seg_d0", seg, 7'b0011001); end
                4'b1101: begin an_hits[1]++; check("scan_seg_d1", seg, 7'b0110000); end
                4'b1011: begin an_hits[2]++; check("scan_seg_d2", seg, 7'b0100100); end
                4'b0111: begin an_hits[3]++; check("scan_seg_d3", seg, 7'b1111001); end
                default: check("scan_an_valid", an, 4'b1110);
            endcase
        end
        for (int i = 0; i < 4; i++) check($sformatf("scan_hold_d%0d", i), an_hits[i], 4);

        // Mid-scan asynchronous reset, cnt_in high through release.
        @(negedge clk);
        cnt_in = 1'b1;
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_an", an, 4'b1110);
        check("mid_rst_seg", seg, 7'b1000000);
        check("mid_rst_bcd", bcd, 16'h0000);
        check("mid_rst_tc", tc, 1'b0);
        @(negedge clk);
        RESET = 1'b0;
        wait_cycles(10);
        check("post_rst_no_tick", bcd, 16'h0000);
        cnt_in = 1'b0;
        wait_cycles(4);
        tick_pulse(16'h0000, 16'h0001, 1'b0, "post_rst_up");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
